// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - Gray-code helpers and overflow-mode constants shared by counters and pointer-sync blocks
package gray_pkg;

  localparam int MAX_W    = 32;
  localparam int WRAP_MOD = 1;
  localparam int WRAP_SAT = 0;

  // Narrower codes are zero-extended into MAX_W; zero upper bits leave both conversions unchanged.
  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/bin2gray_n.sv
// rtl/bin2gray_n.sv - combinational binary-to-Gray converter of parametrised width
module bin2gray_n #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_bin,
  output logic [WIDTH-1:0] o_gray
);

  assign o_gray = i_bin ^ (i_bin >> 1);

endmodule

// File: rtl/gray_counter_n.sv
// rtl/gray_counter_n.sv - registered up/down Gray counter with load and wrap/saturate policy
module gray_counter_n
  import gray_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int WRAP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] gray_out,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_gray;
  logic             r_wrap;
  logic [WIDTH-1:0] w_bin_next;
  logic [WIDTH-1:0] w_gray_next;
  logic [WIDTH-1:0] w_step;
  logic             w_limit;
  logic             w_wrap_next;

  assign w_limit = up ? (&r_bin) : ~(|r_bin);
  assign w_step  = up ? (r_bin + ONE) : (r_bin - ONE);

  // At the limit a step is still taken in modulo mode; saturate mode holds and flags it.
  always_comb begin
    w_bin_next  = r_bin;
    w_wrap_next = 1'b0;
    if (load) begin
      w_bin_next = load_bin;
    end else if (en) begin
      w_wrap_next = w_limit;
      if (!w_limit || (WRAP == WRAP_MOD)) begin
        w_bin_next = w_step;
      end
    end
  end

  bin2gray_n #(.WIDTH(WIDTH)) u_bin2gray (
    .i_bin  (w_bin_next),
    .o_gray (w_gray_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin  <= '0;
      r_gray <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_bin  <= w_bin_next;
      r_gray <= w_gray_next;
      r_wrap <= w_wrap_next;
    end
  end

  assign bin_out  = r_bin;
  assign gray_out = r_gray;
  assign wrap     = r_wrap;

endmodule

// File: tb/tb_gray_counter_n.sv
// tb/tb_gray_counter_n.sv - self-checking bench for gray_counter_n across widths and overflow modes
module tb_gray_counter_n;
  import gray_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       up = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_bin = 8'h00;

  logic [3:0] b4, g4, b4s, g4s;
  logic [1:0] b2, g2;
  logic [7:0] b8, g8;
  logic       w4, w4s, w2, w8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gray_counter_n #(.WIDTH(4), .WRAP(1)) u4 (.clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
    .load_bin(load_bin[3:0]), .bin_out(b4), .gray_out(g4), .wrap(w4));
  gray_counter_n #(.WIDTH(4), .WRAP(0)) u4s (.clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
    .load_bin(load_bin[3:0]), .bin_out(b4s), .gray_out(g4s), .wrap(w4s));
  gray_counter_n #(.WIDTH(2), .WRAP(1)) u2 (.clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
    .load_bin(load_bin[1:0]), .bin_out(b2), .gray_out(g2), .wrap(w2));
  gray_counter_n #(.WIDTH(8), .WRAP(1)) u8 (.clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
    .load_bin(load_bin), .bin_out(b8), .gray_out(g8), .wrap(w8));

  typedef struct packed {
    logic [7:0] bin;
    logic [7:0] gray;
    logic       wrap;
  } dexp_t;

  typedef struct packed {
    logic [3:0][7:0] bin;
    logic [3:0][7:0] gray;
    logic [3:0]      wrap;
  } rexp_t;

  dexp_t dq[$];
  rexp_t rq[$];

  int         inst_w    [4] = '{4, 4, 2, 8};
  int         inst_mod  [4] = '{1, 0, 1, 1};
  logic [7:0] m_bin     [4];
  logic [7:0] prev_gray [4];

  function automatic logic [7:0] act_bin(input int k);
    case (k)
      0:       return {4'h0, b4};
      1:       return {4'h0, b4s};
      2:       return {6'h00, b2};
      default: return b8;
    endcase
  endfunction

  function automatic logic [7:0] act_gray(input int k);
    case (k)
      0:       return {4'h0, g4};
      1:       return {4'h0, g4s};
      2:       return {6'h00, g2};
      default: return g8;
    endcase
  endfunction

  function automatic logic act_wrap(input int k);
    case (k)
      0:       return w4;
      1:       return w4s;
      2:       return w2;
      default: return w8;
    endcase
  endfunction

  function automatic logic [7:0] ref_gray(input logic [7:0] b);
    return b ^ {1'b0, b[7:1]};
  endfunction

  task automatic drive(input logic e, input logic u, input logic l, input logic [7:0] lb);
    en = e;
    up = u;
    load = l;
    load_bin = lb;
    @(posedge clk);
    #1;
  endtask

  task automatic model_step(input logic e, input logic u, input logic l, input logic [7:0] lb,
                            output rexp_t x);
    for (int k = 0; k < 4; k++) begin
      logic [7:0] msk;
      logic [7:0] nb;
      logic       nw;
      msk = 8'((1 << inst_w[k]) - 1);
      nb  = m_bin[k];
      nw  = 1'b0;
      if (l) begin
        nb = lb & msk;
      end else if (e && u) begin
        if (m_bin[k] == msk) begin
          nw = 1'b1;
          nb = (inst_mod[k] == 1) ? 8'h00 : msk;
        end else begin
          nb = m_bin[k] + 8'd1;
        end
      end else if (e) begin
        if (m_bin[k] == 8'h00) begin
          nw = 1'b1;
          nb = (inst_mod[k] == 1) ? msk : 8'h00;
        end else begin
          nb = m_bin[k] - 8'd1;
        end
      end
      m_bin[k]  = nb;
      x.bin[k]  = nb;
      x.gray[k] = ref_gray(nb);
      x.wrap[k] = nw;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (act_bin(k) !== 8'h00 || act_gray(k) !== 8'h00 || act_wrap(k) !== 1'b0) begin
        errors++;
        $display("FAIL reset_state[%0d]: got bin=%h gray=%h wrap=%b, want 0/0/0", k, act_bin(k), act_gray(k), act_wrap(k));
      end
    end
    rst_n = 1'b1;
    repeat (3) drive(1'b1, 1'b1, 1'b0, 8'h00);
    checks++;
    if (b4 !== 4'd3) begin
      errors++;
      $display("FAIL pre_reset_count: got bin=%h, want 3", b4);
    end
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (act_bin(k) !== 8'h00 || act_gray(k) !== 8'h00 || act_wrap(k) !== 1'b0) begin
        errors++;
        $display("FAIL async_reset[%0d]: got bin=%h gray=%h wrap=%b, want 0/0/0", k, act_bin(k), act_gray(k), act_wrap(k));
      end
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    checks++;
    if (b4 !== 4'h0 || g4 !== 4'h0 || w4 !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_hold: got bin=%h gray=%h wrap=%b, want 0/0/0", b4, g4, w4);
    end
  endtask

  task automatic test_up_count();
    logic [3:0] gseq [16];
    dexp_t      x;
    gseq = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
             4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};
    for (int i = 0; i < 17; i++) begin
      x.bin  = 8'((i + 1) % 16);
      x.gray = {4'h0, gseq[(i + 1) % 16]};
      x.wrap = (i == 15);
      dq.push_back(x);
      drive(1'b1, 1'b1, 1'b0, 8'h00);
      x = dq.pop_front();
      checks++;
      if (act_bin(0) !== x.bin || act_gray(0) !== x.gray || act_wrap(0) !== x.wrap) begin
        errors++;
        $display("FAIL up_count[%0d]: got bin=%h gray=%h wrap=%b, want bin=%h gray=%h wrap=%b",
                 i, act_bin(0), act_gray(0), act_wrap(0), x.bin, x.gray, x.wrap);
      end
    end
  endtask

  task automatic test_down_wrap();
    dexp_t x;
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    dq.push_back('{bin: 8'h0f, gray: 8'h08, wrap: 1'b1});
    dq.push_back('{bin: 8'h0f, gray: 8'h08, wrap: 1'b0});
    for (int i = 0; i < 2; i++) begin
      drive(i == 0, 1'b0, 1'b0, 8'h00);
      x = dq.pop_front();
      checks++;
      if (act_bin(0) !== x.bin || act_gray(0) !== x.gray || act_wrap(0) !== x.wrap) begin
        errors++;
        $display("FAIL down_wrap[%0d]: got bin=%h gray=%h wrap=%b, want bin=%h gray=%h wrap=%b",
                 i, act_bin(0), act_gray(0), act_wrap(0), x.bin, x.gray, x.wrap);
      end
    end
    checks++;
    if (b4s !== 4'h0) begin
      errors++;
      $display("FAIL sat_down_hold: got bin=%h, want 0", b4s);
    end
  endtask

  task automatic test_load_priority();
    dexp_t x;
    dq.push_back('{bin: 8'h03, gray: 8'h02, wrap: 1'b0});
    dq.push_back('{bin: 8'h0a, gray: 8'h0f, wrap: 1'b0});
    for (int i = 0; i < 2; i++) begin
      drive(i == 1, i == 1, 1'b1, (i == 0) ? 8'h03 : 8'h0a);
      x = dq.pop_front();
      checks++;
      if (act_bin(0) !== x.bin || act_gray(0) !== x.gray || act_wrap(0) !== x.wrap) begin
        errors++;
        $display("FAIL load_priority[%0d]: got bin=%h gray=%h wrap=%b, want bin=%h gray=%h wrap=%b",
                 i, act_bin(0), act_gray(0), act_wrap(0), x.bin, x.gray, x.wrap);
      end
    end
  endtask

  task automatic test_saturate();
    dexp_t x;
    dq.push_back('{bin: 8'h0e, gray: 8'h09, wrap: 1'b0});
    dq.push_back('{bin: 8'h0f, gray: 8'h08, wrap: 1'b0});
    dq.push_back('{bin: 8'h0f, gray: 8'h08, wrap: 1'b1});
    dq.push_back('{bin: 8'h0f, gray: 8'h08, wrap: 1'b1});
    dq.push_back('{bin: 8'h0e, gray: 8'h09, wrap: 1'b0});
    for (int i = 0; i < 5; i++) begin
      drive(i != 0, i != 4, i == 0, 8'h0e);
      x = dq.pop_front();
      checks++;
      if (act_bin(1) !== x.bin || act_gray(1) !== x.gray || act_wrap(1) !== x.wrap) begin
        errors++;
        $display("FAIL saturate[%0d]: got bin=%h gray=%h wrap=%b, want bin=%h gray=%h wrap=%b",
                 i, act_bin(1), act_gray(1), act_wrap(1), x.bin, x.gray, x.wrap);
      end
    end
  endtask

  task automatic test_random();
    rexp_t x;
    logic  e, u, l;
    logic [7:0] lb;
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      m_bin[k]     = 8'h00;
      prev_gray[k] = 8'h00;
    end
    for (int c = 0; c < 10000; c++) begin
      if ($urandom_range(499) == 0) begin
        #1 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
          checks++;
          if (act_bin(k) !== 8'h00 || act_gray(k) !== 8'h00 || act_wrap(k) !== 1'b0) begin
            errors++;
            $display("FAIL rand_reset[%0d] cyc %0d: got bin=%h gray=%h wrap=%b", k, c, act_bin(k), act_gray(k), act_wrap(k));
          end
          m_bin[k]     = 8'h00;
          prev_gray[k] = 8'h00;
        end
        rst_n = 1'b1;
      end
      e  = ($urandom_range(3) != 0);
      u  = 1'($urandom_range(1));
      l  = ($urandom_range(15) == 0);
      lb = 8'($urandom);
      model_step(e, u, l, lb, x);
      rq.push_back(x);
      drive(e, u, l, lb);
      x = rq.pop_front();
      for (int k = 0; k < 4; k++) begin
        int hd;
        hd = $countones(act_gray(k) ^ prev_gray[k]);
        checks++;
        if (act_bin(k) !== x.bin[k] || act_gray(k) !== x.gray[k] || act_wrap(k) !== x.wrap[k]) begin
          errors++;
          $display("FAIL rand_model[%0d] cyc %0d: got bin=%h gray=%h wrap=%b, want bin=%h gray=%h wrap=%b",
                   k, c, act_bin(k), act_gray(k), act_wrap(k), x.bin[k], x.gray[k], x.wrap[k]);
        end
        checks++;
        if (gray2bin({24'h0, act_gray(k)}) !== {24'h0, act_bin(k)}) begin
          errors++;
          $display("FAIL rand_gray2bin[%0d] cyc %0d: got gray=%h bin=%h", k, c, act_gray(k), act_bin(k));
        end
        if (!l) begin
          checks++;
          if (hd != ((x.gray[k] != prev_gray[k]) ? 1 : 0)) begin
            errors++;
            $display("FAIL rand_hamming[%0d] cyc %0d: got distance %0d, want %0d", k, c, hd,
                     (x.gray[k] != prev_gray[k]) ? 1 : 0);
          end
        end
        prev_gray[k] = act_gray(k);
      end
    end
  endtask

  initial begin
    test_reset();
    test_up_count();
    test_down_wrap();
    test_load_priority();
    test_saturate();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gray_counter_n.md
# gray_counter_n

Parametrised, registered Gray-code counter with a synchronous load, up/down direction, and a selectable wrap or saturate mode. The counter keeps its state in binary. It presents both the binary count and the registered Gray equivalent, so the Gray output is glitch-free and changes exactly one bit per counting step. Its main use is as a pointer source for clock-domain-crossing FIFOs and position encoders. It replaces the fixed 4-bit combinational converter in new designs.

## Interface
Parameters:
- WIDTH, 4, counter and code width in bits; must be ≥ 2.
- WRAP, 1, overflow policy: 1 wraps modulo 2^WIDTH; 0 saturates at the end value.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  count enable; one step per cycle while high.
- up  input  1  direction: 1 increments, 0 decrements; sampled only when en=1.
- load  input  1  synchronous load of load_bin; takes priority over en.
- load_bin  input  WIDTH  binary value to load.
- bin_out  output  WIDTH  registered binary count.
- gray_out  output  WIDTH  registered Gray code of bin_out.
- wrap  output  1  registered one-cycle pulse on wrap (WRAP=1) or blocked step (WRAP=0).

## Operation
- Gray encoding:
  - gray[WIDTH-1] = bin[WIDTH-1].
  - gray[i] = bin[i+1] ^ bin[i] for i < WIDTH-1.
  - Equivalently, gray = bin ^ (bin >> 1).
- Per-cycle priority is load, then en, then hold.
- load=1:
  - bin_next = load_bin and gray_next = gray(load_bin).
  - wrap_next = 0.
  - en and up are ignored.
- en=1, load=0, up=1:
  - WRAP=1: bin_next = bin+1 modulo 2^WIDTH. wrap_next = 1 only when bin = 2^WIDTH−1.
  - WRAP=0: if bin = 2^WIDTH−1, bin holds and wrap_next = 1; otherwise bin_next = bin+1 and wrap_next = 0.
- en=1, load=0, up=0:
  - WRAP=1: bin_next = bin−1 modulo 2^WIDTH. wrap_next = 1 only when bin = 0.
  - WRAP=0: if bin = 0, bin holds and wrap_next = 1; otherwise bin_next = bin−1 and wrap_next = 0.
- en=0, load=0: all state holds and wrap_next = 0.
- gray_out is always gray(bin_out). It is computed from bin_next and registered, never decoded combinationally at the output.
- Width rules: all arithmetic is WIDTH bits. The carry or borrow is used only to detect the wrap or limit condition.
- There is no FSM; the state is the bin register, the gray register, and the wrap flop.

## Timing
- Reset: while rst_n=0, bin_out=0, gray_out=0 and wrap=0, asynchronously. Outputs are held until the first rising clk edge after rst_n deasserts.
- Reset mid-count: the count is lost immediately and the counter restarts from 0. No pending wrap pulse survives reset.
- Latency: one cycle from en/load sampled at edge N to a new bin_out, gray_out and wrap after edge N.
- Throughput: one step per cycle under continuous en.
- Wrap pulse:
  - Lasts exactly one cycle per qualifying step.
  - In saturate mode with en held at the limit, wrap stays high every cycle, one pulse per blocked step.
- Counting steps change gray_out by Hamming distance 1. Load and reset may change any number of bits.
- Changing direction on consecutive cycles is legal, and each step takes effect independently.

## Structure
- Shared package gray_pkg holds:
  - function bin2gray(logic [WIDTH-1:0]), parametrised via a width parameter or a parameterised class/let;
  - function gray2bin (prefix XOR from the MSB down), used by benches and future pointer-sync blocks;
  - the WRAP mode localparams WRAP_MOD=1 and WRAP_SAT=0.
- One natural sub-module: bin2gray_n (parameter WIDTH), a purely combinational converter instantiated on bin_next.
- The counter's datapath and limit logic stay in gray_counter_n.

## Test plan
- Reset and up-count, WIDTH=4, WRAP=1: assert rst_n=0 mid-stream, then release and hold en=1, up=1 for 17 cycles.
  - After reset, bin_out, gray_out and wrap are all 0.
  - gray_out steps 0000, 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, 1111, 1110, 1010, 1011, 1001, 1000, 0000.
  - wrap=1 only in the cycle showing 0000 after 1000.
- Down wrap: from reset, apply en=1, up=0 for one cycle.
  - Result is bin_out=1111, gray_out=1000, wrap=1.
  - With en then dropped, the next cycle shows wrap=0 and the values held.
- Load priority: from bin_out=0011, apply load=1, load_bin=1010 together with en=1, up=1.
  - Result is bin_out=1010, gray_out=1111, wrap=0.
- Saturate, WRAP=0, WIDTH=4: load 1110, then hold en=1, up=1 for 3 cycles.
  - bin_out goes 1111, 1111, 1111 and gray_out stays at 1000.
  - wrap goes 0, 1, 1.
  - Then applying up=0 for one cycle gives bin_out=1110 and wrap=0.
- Randomised en, up and load over 10k cycles, run for WIDTH=2, 4 and 8:
  - gray2bin(gray_out) == bin_out on every cycle;
  - gray Hamming distance is 1 on every counting step and 0 on hold cycles;
  - wrap matches a reference model;
  - includes asynchronous rst_n pulses between clock edges, after each of which all outputs are 0.
